// File: rtl/touch_pkg.sv
// Shared definitions for the touch conversion-enable controller:
// channel state encoding and the default idle timeout.
package touch_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONFIRM = 2'd1;
    localparam logic [1:0] ST_ACTIVE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_CONFIRM = ST_CONFIRM,
        S_ACTIVE  = ST_ACTIVE
    } state_t;

    localparam int TOUCH_TIMEOUT_DEF = 1000000;

endpackage

// File: rtl/touch_enable_ch.sv
// One touch channel: confirms CONFIRM_N coordinate transmissions before enabling
// conversion, and optionally drops the enable after TIMEOUT idle cycles.
module touch_enable_ch
    import touch_pkg::*;
#(
    parameter int CONFIRM_N = 2,
    parameter int TIMEOUT   = TOUCH_TIMEOUT_DEF,
    parameter int STICKY    = 1,
    parameter int CNT_W     = 4,
    parameter int TO_W      = $clog2(TIMEOUT + 1)
) (
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic       iFin,
    input  logic       iClear,
    output logic       oEnable,
    output logic       oFirst_pulse,
    output logic       oTimeout,
    output logic [1:0] oState
);

    localparam logic [CNT_W-1:0] L_CN = CNT_W'(CONFIRM_N);
    localparam logic [TO_W:0]    L_TO = (TO_W + 1)'(TIMEOUT);

    generate
        if (CONFIRM_N < 1 || CONFIRM_N > (2 ** CNT_W) - 1) begin : g_bad_confirm
            $error("touch_enable_ch: CONFIRM_N out of range for CNT_W");
        end
        if (TIMEOUT < 2) begin : g_bad_timeout
            $error("touch_enable_ch: TIMEOUT must be at least 2");
        end
    endgenerate

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [TO_W-1:0]   r_timer;
    logic [TO_W-1:0]   w_timer_nxt;
    logic [TO_W:0]     w_timer_inc;
    logic              w_timer_hit;
    logic              r_first;
    logic              w_first_nxt;
    logic              r_to;
    logic              w_to_nxt;
    logic              w_enable;

    // The extra bit keeps the increment from wrapping before the compare.
    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_timer_inc = {1'b0, r_timer} + (TO_W + 1)'(1);
    assign w_timer_hit = (w_timer_inc >= L_TO);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_timer <= '0;
            r_first <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_timer <= w_timer_nxt;
            r_first <= w_first_nxt;
            r_to    <= w_to_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_timer_nxt = r_timer;
        w_first_nxt = 1'b0;
        w_to_nxt    = 1'b0;
        w_enable    = (r_state == S_ACTIVE);

        if (iClear) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_timer_nxt = '0;
            w_enable    = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_timer_nxt = '0;
                    if (iFin) begin
                        if (CONFIRM_N == 1) begin
                            w_state_nxt = S_ACTIVE;
                            w_first_nxt = 1'b1;
                            w_enable    = 1'b1;
                        end else begin
                            w_state_nxt = S_CONFIRM;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                S_CONFIRM: begin
                    if (iFin) begin
                        w_timer_nxt = '0;
                        if (w_cnt_inc == L_CN) begin
                            w_state_nxt = S_ACTIVE;
                            w_cnt_nxt   = '0;
                            w_first_nxt = 1'b1;
                            w_enable    = 1'b1;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else if (w_timer_hit) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = w_timer_inc[TO_W-1:0];
                    end
                end
                S_ACTIVE: begin
                    if (iFin) begin
                        w_timer_nxt = '0;
                    end else if (STICKY == 0) begin
                        if (w_timer_hit) begin
                            w_state_nxt = S_IDLE;
                            w_timer_nxt = '0;
                            w_to_nxt    = 1'b1;
                        end else begin
                            w_timer_nxt = w_timer_inc[TO_W-1:0];
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_timer_nxt = '0;
                    w_enable    = 1'b0;
                end
            endcase
        end
    end

    assign oEnable      = w_enable;
    assign oFirst_pulse = r_first;
    assign oTimeout     = r_to;
    assign oState       = r_state;

endmodule

// File: rtl/touch_enable_ctrl.sv
// Multi-channel touch conversion-enable controller: N_CH independent channels
// plus an any-channel enable for the shared conversion/display path.
module touch_enable_ctrl
    import touch_pkg::*;
#(
    parameter int N_CH      = 1,
    parameter int CONFIRM_N = 2,
    parameter int TIMEOUT   = TOUCH_TIMEOUT_DEF,
    parameter int STICKY    = 1,
    parameter int CNT_W     = 4,
    parameter int TO_W      = $clog2(TIMEOUT + 1)
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    input  logic [N_CH-1:0]     iFin_transmision,
    input  logic [N_CH-1:0]     iClear,
    output logic [N_CH-1:0]     oEnable_conversion,
    output logic [N_CH-1:0]     oFirst_pulse,
    output logic [N_CH-1:0]     oTimeout,
    output logic                oAny_enable,
    output logic [2*N_CH-1:0]   oDbg_state
);

    logic [N_CH-1:0] w_enable;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        touch_enable_ch #(
            .CONFIRM_N (CONFIRM_N),
            .TIMEOUT   (TIMEOUT),
            .STICKY    (STICKY),
            .CNT_W     (CNT_W),
            .TO_W      (TO_W)
        ) u_ch (
            .iCLK         (iCLK),
            .iRST_n       (iRST_n),
            .iFin         (iFin_transmision[g]),
            .iClear       (iClear[g]),
            .oEnable      (w_enable[g]),
            .oFirst_pulse (oFirst_pulse[g]),
            .oTimeout     (oTimeout[g]),
            .oState       (oDbg_state[2*g +: 2])
        );
    end

    assign oEnable_conversion = w_enable;
    assign oAny_enable        = |w_enable;

endmodule

// File: tb/tb_touch_enable_ctrl.sv
// Bench for touch_enable_ctrl: three instances with different parameter sets,
// checked every cycle against a transmission-counting reference model.
module tb_touch_enable_ctrl;

  // Lane map: 0,1 = dut0 ch0/ch1; 2 = dut1 ch0; 3 = dut2 ch0
  int lane_cn[4]     = '{2, 2, 1, 3};
  int lane_tmo[4]    = '{100, 100, 8, 8};
  int lane_sticky[4] = '{0, 0, 1, 0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] fin0 = '0, clr0 = '0;
  logic [0:0] fin1 = '0, clr1 = '0, fin2 = '0, clr2 = '0;

  logic [1:0] en0, first0, to0;
  logic [0:0] en1, first1, to1, en2, first2, to2;
  logic       any0, any1, any2;
  logic [3:0] st0;
  logic [1:0] st1, st2;

  int errors = 0;
  int checks = 0;

  // model: phase 0 idle, 1 collecting, 2 enabled
  int m_phase[4], m_fins[4], m_idle[4];
  logic m_first[4], m_to[4];
  logic [3:0] e_en, e_first, e_to;
  logic [7:0] e_st;
  logic [2:0] e_any;

  logic [22:0] obs_all, exp_all;
  assign obs_all = {en2, en1, en0, first2, first1, first0, to2, to1, to0,
                    any2, any1, any0, st2, st1, st0};

  always #5 clk = ~clk;

  touch_enable_ctrl #(.N_CH(2), .CONFIRM_N(2), .TIMEOUT(100), .STICKY(0), .CNT_W(4)) dut0 (
    .iCLK(clk), .iRST_n(rst_n), .iFin_transmision(fin0), .iClear(clr0),
    .oEnable_conversion(en0), .oFirst_pulse(first0), .oTimeout(to0),
    .oAny_enable(any0), .oDbg_state(st0));

  touch_enable_ctrl #(.N_CH(1), .CONFIRM_N(1), .TIMEOUT(8), .STICKY(1), .CNT_W(4)) dut1 (
    .iCLK(clk), .iRST_n(rst_n), .iFin_transmision(fin1), .iClear(clr1),
    .oEnable_conversion(en1), .oFirst_pulse(first1), .oTimeout(to1),
    .oAny_enable(any1), .oDbg_state(st1));

  touch_enable_ctrl #(.N_CH(1), .CONFIRM_N(3), .TIMEOUT(8), .STICKY(0), .CNT_W(4)) dut2 (
    .iCLK(clk), .iRST_n(rst_n), .iFin_transmision(fin2), .iClear(clr2),
    .oEnable_conversion(en2), .oFirst_pulse(first2), .oTimeout(to2),
    .oAny_enable(any2), .oDbg_state(st2));

  task automatic model_reset();
    for (int l = 0; l < 4; l++) begin
      m_phase[l] = 0; m_fins[l] = 0; m_idle[l] = 0;
      m_first[l] = 1'b0; m_to[l] = 1'b0;
    end
  endtask

  // Drive one cycle at the falling edge, compute expected outputs for it,
  // then advance the model to what the next cycle should show.
  task automatic step(input logic [3:0] fin, input logic [3:0] clr);
    @(negedge clk);
    fin0 = fin[1:0]; clr0 = clr[1:0];
    fin1[0] = fin[2]; clr1[0] = clr[2];
    fin2[0] = fin[3]; clr2[0] = clr[3];
    for (int l = 0; l < 4; l++) begin
      if (clr[l]) e_en[l] = 1'b0;
      else if (m_phase[l] == 2) e_en[l] = 1'b1;
      else e_en[l] = fin[l] && (m_fins[l] + 1 == lane_cn[l]);
      e_first[l] = m_first[l];
      e_to[l] = m_to[l];
      e_st[2*l +: 2] = 2'(m_phase[l]);
    end
    e_any = {e_en[3], e_en[2], e_en[0] | e_en[1]};
    exp_all = {e_en, e_first, e_to, e_any, e_st};
    #1;
    for (int l = 0; l < 4; l++) begin
      m_first[l] = 1'b0;
      m_to[l] = 1'b0;
      if (clr[l]) begin
        m_phase[l] = 0; m_fins[l] = 0; m_idle[l] = 0;
      end else if (fin[l]) begin
        m_idle[l] = 0;
        if (m_phase[l] != 2) begin
          if (m_fins[l] + 1 == lane_cn[l]) begin
            m_phase[l] = 2; m_fins[l] = 0; m_first[l] = 1'b1;
          end else begin
            m_phase[l] = 1; m_fins[l] = m_fins[l] + 1;
          end
        end
      end else if (m_phase[l] == 1 || (m_phase[l] == 2 && lane_sticky[l] == 0)) begin
        m_idle[l] = m_idle[l] + 1;
        if (m_idle[l] == lane_tmo[l]) begin
          m_to[l] = (m_phase[l] == 2);
          m_phase[l] = 0; m_fins[l] = 0; m_idle[l] = 0;
        end
      end
    end
  endtask

  task automatic test_reset();
    model_reset();
    #3;
    checks++;
    if (obs_all !== 23'd0) begin
      errors++; $display("FAIL reset_hold obs=%h exp=0", obs_all);
    end
    @(negedge clk); #2 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(4'b0000, 4'b0000);
      checks++;
      if (obs_all !== exp_all) begin
        errors++; $display("FAIL reset_idle obs=%h exp=%h", obs_all, exp_all);
      end
    end
  endtask

  task automatic test_confirm();
    step(4'b0001, 4'b0000);
    for (int c = 0; c < 9; c++) begin
      step(4'b0000, 4'b0000);
      checks++;
      if (obs_all !== exp_all) begin
        errors++; $display("FAIL confirm_gap obs=%h exp=%h", obs_all, exp_all);
      end
    end
    step(4'b0001, 4'b0000);
    checks++;
    if (en0 !== 2'b01) begin
      errors++; $display("FAIL confirm_enable obs=%b exp=01", en0);
    end
    step(4'b0000, 4'b0000);
    checks++;
    if (first0 !== 2'b01 || en0 !== 2'b01) begin
      errors++; $display("FAIL confirm_first obs=%b/%b exp=01/01", first0, en0);
    end
    step(4'b0000, 4'b0000);
    checks++;
    if (first0 !== 2'b00 || obs_all !== exp_all) begin
      errors++; $display("FAIL confirm_first_end obs=%h exp=%h", obs_all, exp_all);
    end
  endtask

  task automatic test_sticky();
    step(4'b0100, 4'b0000);
    checks++;
    if (en1 !== 1'b1) begin
      errors++; $display("FAIL sticky_same_cycle obs=%b exp=1", en1);
    end
    for (int c = 0; c < 24; c++) begin
      step(4'b0000, 4'b0000);
      checks++;
      if (en1 !== 1'b1 || to1 !== 1'b0 || obs_all !== exp_all) begin
        errors++; $display("FAIL sticky_hold c=%0d obs=%h exp=%h", c, obs_all, exp_all);
      end
    end
  endtask

  task automatic test_confirm_timeout();
    step(4'b1000, 4'b0000);
    for (int c = 1; c <= 9; c++) begin
      step(4'b0000, 4'b0000);
      checks++;
      if (st2 !== ((c <= 8) ? 2'd1 : 2'd0) || to2 !== 1'b0 || obs_all !== exp_all) begin
        errors++; $display("FAIL confirm_timeout c=%0d st=%0d to=%b", c, st2, to2);
      end
    end
    for (int p = 1; p <= 3; p++) begin
      step(4'b1000, 4'b0000);
      checks++;
      if (en2 !== ((p == 3) ? 1'b1 : 1'b0) || obs_all !== exp_all) begin
        errors++; $display("FAIL confirm3 p=%0d obs=%b exp=%b", p, en2, (p == 3));
      end
      if (p != 3) step(4'b0000, 4'b0000);
    end
  endtask

  task automatic test_timeout();
    for (int c = 0; c < 6; c++) step(4'b0000, 4'b0000);
    step(4'b1000, 4'b0000);
    for (int c = 1; c <= 10; c++) begin
      step(4'b0000, 4'b0000);
      checks++;
      if (en2 !== ((c <= 8) ? 1'b1 : 1'b0) || to2 !== ((c == 9) ? 1'b1 : 1'b0)
          || obs_all !== exp_all) begin
        errors++; $display("FAIL timeout c=%0d en=%b to=%b exp=%h obs=%h", c, en2, to2, exp_all, obs_all);
      end
    end
  endtask

  task automatic test_clear();
    step(4'b0000, 4'b0100);
    checks++;
    if (en1 !== 1'b0 || obs_all !== exp_all) begin
      errors++; $display("FAIL clear_active obs=%b exp=0", en1);
    end
    step(4'b0000, 4'b0000);
    checks++;
    if (st1 !== 2'd0 || to1 !== 1'b0 || en1 !== 1'b0) begin
      errors++; $display("FAIL clear_after st=%0d to=%b en=%b", st1, to1, en1);
    end
    step(4'b0100, 4'b0100);
    checks++;
    if (en1 !== 1'b0) begin
      errors++; $display("FAIL clear_fin_same obs=%b exp=0", en1);
    end
    step(4'b0000, 4'b0000);
    checks++;
    if (st1 !== 2'd0 || en1 !== 1'b0 || first1 !== 1'b0 || obs_all !== exp_all) begin
      errors++; $display("FAIL clear_fin_idle st=%0d en=%b", st1, en1);
    end
  endtask

  task automatic test_async_reset();
    step(4'b0101, 4'b0000);
    step(4'b1000, 4'b0000);
    step(4'b0000, 4'b0000);
    @(posedge clk);
    fin0 = '0; clr0 = '0; fin1 = '0; clr1 = '0; fin2 = '0; clr2 = '0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs_all !== 23'd0) begin
      errors++; $display("FAIL async_reset obs=%h exp=0", obs_all);
    end
    #4 rst_n = 1'b1;
    step(4'b1001, 4'b0000);
    step(4'b0000, 4'b0000);
    checks++;
    if (en0[0] !== 1'b0 || st0[1:0] !== 2'd1 || obs_all !== exp_all) begin
      errors++; $display("FAIL reset_reconfirm1 obs=%h exp=%h", obs_all, exp_all);
    end
    step(4'b0001, 4'b0000);
    checks++;
    if (en0[0] !== 1'b1 || obs_all !== exp_all) begin
      errors++; $display("FAIL reset_reconfirm2 obs=%h exp=%h", obs_all, exp_all);
    end
  endtask

  task automatic test_random();
    logic [3:0] f, c;
    for (int n = 0; n < 600; n++) begin
      for (int l = 0; l < 4; l++) begin
        f[l] = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
        c[l] = ($urandom_range(0, 49) == 0);
      end
      step(f, c);
      checks++;
      if (obs_all !== exp_all) begin
        errors++; $display("FAIL random n=%0d obs=%h exp=%h", n, obs_all, exp_all);
      end
    end
  endtask

  initial begin
    test_reset();
    test_confirm();
    test_sticky();
    test_confirm_timeout();
    test_timeout();
    test_clear();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
